// File: rtl/visumon_pkg.sv
`default_nettype none
// =============================================================================
// Module   : visumon_pkg
// Purpose  : Shared types for the visuMon debug-LED bus (writer and receiver).
// Revision : 1.0
// =============================================================================
package visumon_pkg;

  localparam int LED_COUNT = 64;

  typedef struct packed {
    logic [5:0] ledNo;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       status;
  } debugInfo_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    LOAD   = 3'd4
  } state_t;

  // Blanking word for one LED: colours and status forced off.
  function automatic debugInfo_t clear_word(input logic [5:0] led_no);
    debugInfo_t w;
    w       = '0;
    w.ledNo = led_no;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/visumon_fifo.sv
`default_nettype none
// =============================================================================
// Module   : visumon_fifo
// Purpose  : Synchronous show-ahead FIFO with full/empty flags.
// Revision : 1.0
// =============================================================================
module visumon_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign o_rdata = r_mem[r_rptr[c_AW-1:0]];

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + (c_AW+1)'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + (c_AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/visumon_led_writer.sv
`default_nettype none
// =============================================================================
// Module   : visumon_led_writer
// Purpose  : Buffers LED updates and frames them onto the visuMon bus with cs.
// Revision : 1.0
// =============================================================================
module visumon_led_writer
  import visumon_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [5:0] i_ledNo,
  input  logic [3:0] i_red,
  input  logic [3:0] i_green,
  input  logic [3:0] i_blue,
  input  logic       i_on,
  input  logic       i_clearAll,
  output debugInfo_t o_debugInfo,
  output logic       o_cs,
  output logic       o_busy,
  output logic [7:0] o_dropCount
);

  localparam int c_MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int c_MAX_CYC = (c_MAX_A > HOLD_CYCLES) ? c_MAX_A : HOLD_CYCLES;
  localparam int c_CW      = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  localparam logic [c_CW-1:0] c_SETUP_LAST  = c_CW'(SETUP_CYCLES - 1);
  localparam logic [c_CW-1:0] c_STROBE_LAST = c_CW'(STROBE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST   = c_CW'(HOLD_CYCLES - 1);
  localparam logic [5:0]      c_LAST_LED    = 6'(LED_COUNT - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [c_CW-1:0] r_cnt;
  logic            w_last;

  debugInfo_t      w_req;
  debugInfo_t      w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_load_clear;
  logic            w_frame_done;
  logic            w_cs_next;

  debugInfo_t      r_bus;
  logic            r_cs;
  logic [7:0]      r_drop;
  logic            r_clear_pending;
  logic [5:0]      r_clr_cnt;
  logic            r_clr_frame;

  assign w_req  = {i_ledNo, i_red, i_green, i_blue, i_on};
  assign w_push = i_valid && !w_full;

  visumon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(debugInfo_t))
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .i_push  (w_push),
    .i_wdata (w_req),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dwell counter restarts on every state change.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      SETUP:   w_last = (r_cnt == c_SETUP_LAST);
      STROBE:  w_last = (r_cnt == c_STROBE_LAST);
      HOLD:    w_last = (r_cnt == c_HOLD_LAST);
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_clear_pending) begin
          w_state_next = LOAD;
        end else if (!w_empty) begin
          w_state_next = SETUP;
        end
      end
      LOAD:    w_state_next = SETUP;
      SETUP:   if (w_last) w_state_next = STROBE;
      STROBE:  if (w_last) w_state_next = HOLD;
      HOLD:    if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pop        = (r_state == IDLE) && !r_clear_pending && !w_empty;
    w_load_clear = (r_state == LOAD);
    w_frame_done = (r_state == HOLD) && w_last;
    w_cs_next    = (w_state_next != STROBE);
  end

  // cs comes straight from a flop so visuMon never sees a decode glitch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cs  <= 1'b1;
      r_bus <= '0;
    end else begin
      r_cs <= w_cs_next;
      if (w_pop) begin
        r_bus <= w_head;
      end else if (w_load_clear) begin
        r_bus <= clear_word(r_clr_cnt);
      end
    end
  end

  // A new clear request disowns the frame in flight so it cannot advance the restarted count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clear_pending <= 1'b0;
      r_clr_cnt       <= '0;
      r_clr_frame     <= 1'b0;
    end else if (i_clearAll) begin
      r_clear_pending <= 1'b1;
      r_clr_cnt       <= '0;
      r_clr_frame     <= 1'b0;
    end else begin
      if (w_load_clear) begin
        r_clr_frame <= 1'b1;
      end else if (w_frame_done) begin
        r_clr_frame <= 1'b0;
      end
      if (w_frame_done && r_clr_frame) begin
        r_clr_cnt <= r_clr_cnt + 6'd1;
        if (r_clr_cnt == c_LAST_LED) begin
          r_clear_pending <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_drop <= '0;
    end else if (i_valid && w_full && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign o_ready     = !w_full;
  assign o_debugInfo = r_bus;
  assign o_cs        = r_cs;
  assign o_dropCount = r_drop;
  assign o_busy      = (r_state != IDLE) || !w_empty || r_clear_pending;

endmodule
`default_nettype wire

// File: tb/tb_visumon_led_writer.sv
`default_nettype none
// =============================================================================
// Module   : tb_visumon_led_writer
// Purpose  : Randomised self-checking bench for visumon_led_writer.
// Revision : 1.0
// =============================================================================
module tb_visumon_led_writer;

  localparam int SETUP  = 2;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 6000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        on = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  led = '0;
  logic [3:0]  r = '0;
  logic [3:0]  g = '0;
  logic [3:0]  b = '0;
  logic        ready;
  logic        cs;
  logic        busy;
  logic [18:0] dbg;
  logic [7:0]  drops;

  always #5 clk = ~clk;

  visumon_led_writer #(
    .FIFO_DEPTH    (DEPTH),
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STROBE),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_ledNo     (led),
    .i_red       (r),
    .i_green     (g),
    .i_blue      (b),
    .i_on        (on),
    .i_clearAll  (clr),
    .o_debugInfo (dbg),
    .o_cs        (cs),
    .o_busy      (busy),
    .o_dropCount (drops)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: requests awaiting transmission, clear sweep state, drop count.
  logic [18:0] q[$];
  logic        m_clr = 1'b0;
  int          m_idx = 0;
  int          m_drop = 0;
  logic        prev_cs = 1'b1;
  logic [18:0] prev_dbg = '0;
  int          last_change = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  logic [18:0] fall_words[$];
  int          fall_cycs[$];

  always @(negedge clk) begin : mon
    logic [18:0] exp_w;
    if (rst) begin
      q.delete();
      m_clr       = 1'b0;
      m_idx       = 0;
      m_drop      = 0;
      prev_cs     = 1'b1;
      prev_dbg    = '0;
      last_change = cyc;
      rise_cyc    = cyc - HOLD;
    end else begin
      check("drop_count", drops, m_drop);
      check("occupancy_bound", q.size() <= DEPTH + 1, 1);
      if (!ready) check("ready_low_only_when_full", q.size() >= DEPTH, 1);
      else        check("ready_high_with_space", q.size() <= DEPTH, 1);
      if (!cs) check("busy_while_strobe", busy, 1);
      if (q.size() > 0 || m_clr) check("busy_with_work", busy, 1);

      if (dbg !== prev_dbg) begin
        check("bus_change_cs_high", {prev_cs, cs}, 2'b11);
        check("bus_hold_after_rise", (cyc - rise_cyc) >= HOLD, 1);
        last_change = cyc;
      end

      if (prev_cs && !cs) begin
        check("bus_setup", (cyc - last_change) >= SETUP, 1);
        exp_w = '0;
        if (m_clr) begin
          exp_w = {6'(m_idx), 13'd0};
          m_idx++;
          if (m_idx == 64) begin
            m_clr = 1'b0;
            m_idx = 0;
          end
        end else if (q.size() > 0) begin
          exp_w = q.pop_front();
        end else begin
          check("frame_expected", 0, 1);
        end
        check("frame_word", dbg, exp_w);
        fall_cyc = cyc;
        fall_words.push_back(dbg);
        fall_cycs.push_back(cyc);
      end

      if (!prev_cs && cs) begin
        check("strobe_len", cyc - fall_cyc, STROBE);
        rise_cyc = cyc;
      end

      if (valid && ready) q.push_back({led, r, g, b, on});
      if (valid && !ready && m_drop < 255) m_drop++;
      if (clr) begin
        m_clr = 1'b1;
        m_idx = 0;
      end
      prev_cs  = cs;
      prev_dbg = dbg;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int idle_c);
    int n = 0;
    while ((busy || q.size() != 0 || m_clr) && n < LIMIT) begin
      tick();
      n++;
    end
    check("drain_in_time", n < LIMIT, 1);
    idle_c = cyc;
  endtask

  task automatic push1(input logic [18:0] w);
    {led, r, g, b, on} = w;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (cs && n < 100) begin
      tick();
      n++;
    end
    check("cs_fall_seen", cs, 0);
  endtask

  initial begin
    int   t0;
    int   n;
    int   idx;
    int   idle_c;
    int   rej;
    logic rdy;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_cs", cs, 1);
    check("rst_bus", dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_drops", drops, 0);
    check("rst_ready", ready, 1);
    rst = 1'b0;
    tick();

    // Single request: latency, word, strobe width, hold.
    {led, r, g, b, on} = {6'd5, 4'hF, 4'h0, 4'h3, 1'b1};
    valid = 1'b1;
    t0 = cyc;
    tick();
    valid = 1'b0;
    n = 0;
    while (cs && n < 20) begin
      tick();
      n++;
    end
    check("first_latency", cyc - t0, 4);
    check("first_word", dbg, 19'h0BE07);
    n = 0;
    while (!cs && n < 20) begin
      tick();
      n++;
    end
    check("first_strobe_cycles", n, 2);
    check("first_hold_bus", dbg, 19'h0BE07);
    drain(idle_c);

    // Six requests with valid held high.
    fall_words.delete();
    fall_cycs.delete();
    idx = 0;
    n = 0;
    valid = 1'b1;
    while (idx < 6 && n < 200) begin
      led = 6'(idx + 8);
      r = 4'(idx);
      g = 4'(15 - idx);
      b = 4'(idx * 3);
      on = 1'(idx);
      rdy = ready;
      tick();
      if (rdy) idx++;
      n++;
    end
    valid = 1'b0;
    check("b2b_all_accepted", idx, 6);
    check("b2b_drops", drops, 3);
    drain(idle_c);
    check("b2b_frames", fall_cycs.size(), 6);
    for (int i = 1; i < fall_cycs.size(); i++) begin
      check("b2b_spacing", fall_cycs[i] - fall_cycs[i-1], 6);
    end

    // Clear with one frame in flight and two queued.
    fall_words.delete();
    fall_cycs.delete();
    push1(19'h02223);
    push1(19'h04444);
    push1(19'h06667);
    wait_cs_low();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drain(idle_c);
    check("clr_frames", fall_words.size(), 67);
    if (fall_words.size() >= 67) begin
      check("clr_inflight_first", fall_words[0], 19'h02223);
      check("clr_led0", fall_words[1], 19'h00000);
      check("clr_led63", fall_words[64], 19'h7E000);
      check("clr_queued_1", fall_words[65], 19'h04444);
      check("clr_queued_2", fall_words[66], 19'h06667);
      check("clr_busy_fall", idle_c - fall_cycs[66], STROBE + HOLD);
    end

    // Clear restarted part-way through a sweep.
    fall_words.delete();
    fall_cycs.delete();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (fall_words.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    check("restart_cs_low", cs, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drain(idle_c);
    check("restart_frames", fall_words.size(), 69);
    if (fall_words.size() >= 69) begin
      check("restart_led4", fall_words[4], 19'h08000);
      check("restart_back_to_0", fall_words[5], 19'h00000);
      check("restart_last", fall_words[68], 19'h7E000);
    end

    // Asynchronous reset while cs is low.
    push1(19'h02223);
    push1(19'h04444);
    wait_cs_low();
    #2 rst = 1'b1;
    #1;
    check("arst_cs", cs, 1);
    check("arst_drops", drops, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    fall_words.delete();
    fall_cycs.delete();
    push1(19'h42246);
    drain(idle_c);
    check("arst_frames", fall_words.size(), 1);
    if (fall_words.size() >= 1) check("arst_word", fall_words[0], 19'h42246);

    // Randomised traffic with occasional clears.
    fall_words.delete();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 2) == 0);
      led   = 6'($urandom);
      r     = 4'($urandom);
      g     = 4'($urandom);
      b     = 4'($urandom);
      on    = 1'($urandom);
      clr   = (!cs && $urandom_range(0, 199) == 0);
      tick();
    end
    valid = 1'b0;
    clr   = 1'b0;
    drain(idle_c);
    check("random_frames_seen", fall_words.size() > 0, 1);

    // Saturation of the drop counter.
    rej = 0;
    n = 0;
    valid = 1'b1;
    while (rej < 300 && n < 3000) begin
      led = 6'($urandom);
      rdy = ready;
      tick();
      if (!rdy) rej++;
      n++;
    end
    valid = 1'b0;
    check("sat_rejected", rej, 300);
    check("sat_drops", drops, 255);
    drain(idle_c);
    check("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
